// File: rtl/time_view.sv
// Time-of-day clock with four alarm registers, 12/24-hour BCD entry and display.
// Time and alarms are held as 24-hour binary; conversion happens only at the edges.
module time_view #(
    parameter int CLKS_PER_SEC = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode12h,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        button1,
    input  logic        button2,
    input  logic [1:0]  alarm_id,
    input  logic [19:0] stime_alarm,
    input  logic        sam_pm,
    output logic [19:0] hh_mm_ss,
    output logic        am_pm
);
    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0] presc_reg;
    logic [4:0]    hour_reg;
    logic [5:0]    min_reg;
    logic [5:0]    sec_reg;
    logic          btn1_reg;
    logic          btn2_reg;
    logic          btn1_edge;
    logic          btn2_edge;
    logic [4:0]    hour_half;
    logic [4:0]    hour_base;
    logic [4:0]    set_hour_next;

    assign btn1_edge = button1 & ~btn1_reg;
    assign btn2_edge = button2 & ~btn2_reg;

    // While setting, the hour stays inside the AM or PM half chosen by sam_pm.
    always_comb begin
        hour_half     = (hour_reg >= 5'd12) ? hour_reg - 5'd12 : hour_reg;
        hour_base     = sam_pm ? 5'd12 : 5'd0;
        set_hour_next = hour_half + hour_base;
        if (btn1_edge)
            set_hour_next = ((hour_half == 5'd11) ? 5'd0 : hour_half + 5'd1) + hour_base;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_reg <= '0;
            hour_reg  <= '0;
            min_reg   <= '0;
            sec_reg   <= '0;
            btn1_reg  <= 1'b0;
            btn2_reg  <= 1'b0;
        end else begin
            btn1_reg <= button1;
            btn2_reg <= button2;
            if (set_time) begin
                presc_reg <= '0;
                sec_reg   <= '0;
                hour_reg  <= set_hour_next;
                if (btn2_edge)
                    min_reg <= (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
            end else if (presc_reg == PRESC_LAST) begin
                presc_reg <= '0;
                if (sec_reg == 6'd59) begin
                    sec_reg <= 6'd0;
                    if (min_reg == 6'd59) begin
                        min_reg  <= 6'd0;
                        hour_reg <= (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
                    end else begin
                        min_reg <= min_reg + 6'd1;
                    end
                end else begin
                    sec_reg <= sec_reg + 6'd1;
                end
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

    logic [5:0] in_hour_val;
    logic [5:0] in_min_val;
    logic [5:0] in_sec_val;
    logic [4:0] in_hour_24;
    logic       in_hour_ok;
    logic       in_min_ok;
    logic       in_sec_ok;
    logic       alarm_wr;

    // Values are only meaningful when the matching *_ok flag is set.
    always_comb begin
        in_hour_val = 6'(stime_alarm[19:18]) * 6'd10 + 6'(stime_alarm[17:14]);
        in_min_val  = 6'(stime_alarm[13:11]) * 6'd10 + 6'(stime_alarm[10:7]);
        in_sec_val  = 6'(stime_alarm[6:4]) * 6'd10 + 6'(stime_alarm[3:0]);
        in_hour_ok  = (stime_alarm[17:14] <= 4'd9) &&
                      (mode12h ? (in_hour_val >= 6'd1 && in_hour_val <= 6'd12)
                               : (in_hour_val <= 6'd23));
        in_min_ok   = (stime_alarm[13:11] <= 3'd5) && (stime_alarm[10:7] <= 4'd9);
        in_sec_ok   = (stime_alarm[6:4] <= 3'd5) && (stime_alarm[3:0] <= 4'd9);
        in_hour_24  = in_hour_val[4:0];
        if (mode12h) begin
            if (in_hour_val == 6'd12)
                in_hour_24 = sam_pm ? 5'd12 : 5'd0;
            else
                in_hour_24 = in_hour_val[4:0] + (sam_pm ? 5'd12 : 5'd0);
        end
        alarm_wr = set_alarm & ~set_time & in_hour_ok & in_min_ok & in_sec_ok;
    end

    logic [16:0] alarm_word [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_alarm
            logic [16:0] alarm_reg;
            always_ff @(posedge clk) begin
                if (!rst)
                    alarm_reg <= '0;
                else if (alarm_wr && alarm_id == 2'(gi))
                    alarm_reg <= {in_hour_24, in_min_val, in_sec_val};
            end
            assign alarm_word[gi] = alarm_reg;
        end
    endgenerate

    function automatic logic [6:0] to_bcd(input logic [5:0] v);
        return {3'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    logic [4:0] show_hour;
    logic [5:0] show_min;
    logic [5:0] show_sec;
    logic [4:0] disp_hour;
    logic [4:0] hour_tens_val;
    logic [1:0] hour_tens;
    logic [3:0] hour_units;
    logic [6:0] min_bcd;
    logic [6:0] sec_bcd;

    always_comb begin
        if (set_alarm && !set_time)
            {show_hour, show_min, show_sec} = alarm_word[alarm_id];
        else
            {show_hour, show_min, show_sec} = {hour_reg, min_reg, sec_reg};
        disp_hour = show_hour;
        if (mode12h) begin
            if (show_hour == 5'd0)
                disp_hour = 5'd12;
            else if (show_hour > 5'd12)
                disp_hour = show_hour - 5'd12;
        end
        if (disp_hour >= 5'd20) begin
            hour_tens     = 2'd2;
            hour_tens_val = 5'd20;
        end else if (disp_hour >= 5'd10) begin
            hour_tens     = 2'd1;
            hour_tens_val = 5'd10;
        end else begin
            hour_tens     = 2'd0;
            hour_tens_val = 5'd0;
        end
        hour_units = 4'(disp_hour - hour_tens_val);
        min_bcd    = to_bcd(show_min);
        sec_bcd    = to_bcd(show_sec);
    end

    assign hh_mm_ss = {hour_tens, hour_units, min_bcd, sec_bcd};
    assign am_pm    = mode12h & (show_hour >= 5'd12);

endmodule

// File: tb/tb_time_view.sv
// Self-checking bench for time_view: timekeeping, setting, alarm entry and display.
module tb_time_view;
    logic        clk = 1'b0;
    logic        rst;
    logic        mode12h;
    logic        set_time;
    logic        set_alarm;
    logic        button1;
    logic        button2;
    logic [1:0]  alarm_id;
    logic [19:0] stime_alarm;
    logic        sam_pm;
    logic [19:0] hh_mm_ss;
    logic        am_pm;

    always #5 clk = ~clk;

    time_view #(.CLKS_PER_SEC(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode12h     (mode12h),
        .set_time    (set_time),
        .set_alarm   (set_alarm),
        .button1     (button1),
        .button2     (button2),
        .alarm_id    (alarm_id),
        .stime_alarm (stime_alarm),
        .sam_pm      (sam_pm),
        .hh_mm_ss    (hh_mm_ss),
        .am_pm       (am_pm)
    );

    typedef struct {
        string       name;
        logic [19:0] hms;
        logic        ap;
    } exp_t;

    typedef struct {
        string       name;
        logic        m12;
        logic        pm;
        logic [1:0]  id;
        logic [19:0] entry;
        logic [19:0] hms;
        logic        ap;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [19:0] bcd(input int h, input int m, input int s);
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        ht = 2'(h / 10);
        hu = 4'(h % 10);
        mt = 3'(m / 10);
        mu = 4'(m % 10);
        st = 3'(s / 10);
        su = 4'(s % 10);
        return {ht, hu, mt, mu, st, su};
    endfunction

    task automatic add_vec(input string n, input logic m12, input logic pm, input logic [1:0] id,
                           input logic [19:0] entry, input logic [19:0] hms, input logic ap);
        vec_t v;
        v.name  = n;
        v.m12   = m12;
        v.pm    = pm;
        v.id    = id;
        v.entry = entry;
        v.hms   = hms;
        v.ap    = ap;
        vecs.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic b1, input logic b2);
        button1 = b1;
        button2 = b2;
        tick(1);
        button1 = 1'b0;
        button2 = 1'b0;
        tick(1);
    endtask

    task automatic check(input string name, input logic [19:0] hms, input logic ap);
        exp_t e;
        exp_t got;
        e.name = name;
        e.hms  = hms;
        e.ap   = ap;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        checks++;
        if (hh_mm_ss !== got.hms || am_pm !== got.ap) begin
            failures++;
            $display("FAIL %s: got %02h:%02h:%02h am_pm=%0b, expected %02h:%02h:%02h am_pm=%0b",
                     got.name, hh_mm_ss[19:14], hh_mm_ss[13:7], hh_mm_ss[6:0], am_pm,
                     got.hms[19:14], got.hms[13:7], got.hms[6:0], got.ap);
        end else begin
            $display("ok   %s: %02h:%02h:%02h am_pm=%0b",
                     got.name, hh_mm_ss[19:14], hh_mm_ss[13:7], hh_mm_ss[6:0], am_pm);
        end
    endtask

    initial begin
        logic [19:0] bad;
        logic [19:0] bad_digit;
        bad       = 20'hFFFFF;
        bad_digit = {2'd0, 4'd5, 3'd0, 4'hA, 3'd0, 4'd0};

        add_vec("al2_12am",    1'b1, 1'b0, 2'd2, bcd(12, 30, 0),  bcd(12, 30, 0),  1'b0);
        add_vec("al2_24view",  1'b0, 1'b0, 2'd2, bad,             bcd(0, 30, 0),   1'b0);
        add_vec("al2_h13_12h", 1'b1, 1'b0, 2'd2, bcd(13, 0, 0),   bcd(12, 30, 0),  1'b0);
        add_vec("al1_pm7",     1'b1, 1'b1, 2'd1, bcd(7, 15, 45),  bcd(7, 15, 45),  1'b1);
        add_vec("al1_24view",  1'b0, 1'b0, 2'd1, bad,             bcd(19, 15, 45), 1'b0);
        add_vec("al0_24h",     1'b0, 1'b1, 2'd0, bcd(23, 59, 59), bcd(23, 59, 59), 1'b0);
        add_vec("al0_min60",   1'b0, 1'b0, 2'd0, bcd(10, 60, 0),  bcd(23, 59, 59), 1'b0);
        add_vec("al0_sec60",   1'b1, 1'b0, 2'd0, bcd(10, 0, 60),  bcd(11, 59, 59), 1'b1);
        add_vec("al3_12pm",    1'b1, 1'b1, 2'd3, bcd(12, 0, 1),   bcd(12, 0, 1),   1'b1);
        add_vec("al3_h0_12h",  1'b1, 1'b0, 2'd3, bcd(0, 5, 5),    bcd(12, 0, 1),   1'b1);
        add_vec("al3_24view",  1'b0, 1'b0, 2'd3, bad,             bcd(12, 0, 1),   1'b0);
        add_vec("al2_h24",     1'b0, 1'b0, 2'd2, bcd(24, 0, 0),   bcd(0, 30, 0),   1'b0);
        add_vec("al1_digit",   1'b0, 1'b0, 2'd1, bad_digit,       bcd(19, 15, 45), 1'b0);
        add_vec("al0_view12",  1'b1, 1'b0, 2'd0, bad,             bcd(11, 59, 59), 1'b1);

        rst         = 1'b0;
        mode12h     = 1'b0;
        set_time    = 1'b0;
        set_alarm   = 1'b0;
        button1     = 1'b0;
        button2     = 1'b0;
        alarm_id    = 2'd0;
        stime_alarm = '0;
        sam_pm      = 1'b0;

        // Reset state and free-running seconds
        tick(2);
        check("reset_24h", bcd(0, 0, 0), 1'b0);
        mode12h = 1'b1;
        check("reset_12h", bcd(12, 0, 0), 1'b0);
        mode12h = 1'b0;
        rst = 1'b1;
        tick(99);
        check("idle_99", bcd(0, 0, 9), 1'b0);
        tick(1);
        check("idle_100", bcd(0, 0, 10), 1'b0);

        // Time setting with hour wrap inside each half
        set_time = 1'b1;
        for (int i = 0; i < 12; i++) press(1'b1, 1'b0);
        for (int i = 0; i < 34; i++) press(1'b0, 1'b1);
        check("set_00_34", bcd(0, 34, 0), 1'b0);
        sam_pm = 1'b1;
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        check("set_15_34", bcd(15, 34, 0), 1'b0);
        mode12h = 1'b1;
        check("set_15_34_12h", bcd(3, 34, 0), 1'b1);
        tick(30);
        check("set_frozen", bcd(3, 34, 0), 1'b1);
        mode12h = 1'b0;
        for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
        for (int i = 0; i < 25; i++) press(1'b0, 1'b1);
        check("set_23_59", bcd(23, 59, 0), 1'b0);
        press(1'b0, 1'b1);
        check("min_wrap_nocarry", bcd(23, 0, 0), 1'b0);
        for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
        check("set_23_59_again", bcd(23, 59, 0), 1'b0);

        // Midnight rollover
        set_time = 1'b0;
        tick(590);
        check("run_23_59_59", bcd(23, 59, 59), 1'b0);
        mode12h = 1'b1;
        check("run_23_59_59_12h", bcd(11, 59, 59), 1'b1);
        mode12h = 1'b0;
        tick(10);
        check("rollover_24h", bcd(0, 0, 0), 1'b0);
        mode12h = 1'b1;
        check("rollover_12h", bcd(12, 0, 0), 1'b0);
        mode12h = 1'b0;

        // Simultaneous presses and held buttons
        set_time = 1'b1;
        sam_pm   = 1'b0;
        press(1'b1, 1'b1);
        check("both_buttons", bcd(1, 1, 0), 1'b0);
        button1 = 1'b1;
        tick(100);
        button1 = 1'b0;
        tick(1);
        check("hold_b1", bcd(2, 1, 0), 1'b0);
        button2 = 1'b1;
        tick(100);
        button2 = 1'b0;
        tick(1);
        check("hold_b2", bcd(2, 2, 0), 1'b0);
        set_time = 1'b0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("buttons_ignored", bcd(2, 2, 0), 1'b0);

        // set_time wins over set_alarm
        set_time    = 1'b1;
        set_alarm   = 1'b1;
        alarm_id    = 2'd0;
        stime_alarm = bcd(1, 2, 3);
        tick(1);
        check("prio_shows_time", bcd(2, 2, 0), 1'b0);
        set_time    = 1'b0;
        stime_alarm = bad;
        tick(1);
        check("prio_no_write", bcd(0, 0, 0), 1'b0);

        // Alarm entry vectors
        for (int i = 0; i < vecs.size(); i++) begin
            mode12h     = vecs[i].m12;
            sam_pm      = vecs[i].pm;
            alarm_id    = vecs[i].id;
            stime_alarm = vecs[i].entry;
            tick(1);
            check(vecs[i].name, vecs[i].hms, vecs[i].ap);
        end

        // Reset in the middle of a setting session
        set_alarm = 1'b0;
        mode12h   = 1'b0;
        sam_pm    = 1'b0;
        set_time  = 1'b1;
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) press(1'b0, 1'b1);
        check("partial_set", bcd(5, 4, 0), 1'b0);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("reset_mid_set", bcd(0, 0, 0), 1'b0);
        press(1'b1, 1'b0);
        check("set_after_reset", bcd(1, 0, 0), 1'b0);
        set_time    = 1'b0;
        set_alarm   = 1'b1;
        stime_alarm = bad;
        alarm_id    = 2'd1;
        tick(1);
        check("alarm1_cleared", bcd(0, 0, 0), 1'b0);
        alarm_id = 2'd3;
        tick(1);
        check("alarm3_cleared", bcd(0, 0, 0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
